// File: rtl/alu_wb_pkg.sv
// alu_wb_pkg: shared widths, opcode map and FSM state encoding for the writeback stage
package alu_wb_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int OP_W = 6;
  localparam logic [OP_W-1:0] OP_MOV   = 6'h00;
  localparam logic [OP_W-1:0] OP_MOVI  = 6'h01;
  localparam logic [OP_W-1:0] OP_LOAD  = 6'h02;
  localparam logic [OP_W-1:0] OP_STORE = 6'h03;
  localparam logic [OP_W-1:0] OP_ADD   = 6'h04;
  localparam logic [OP_W-1:0] OP_SUB   = 6'h05;
  localparam logic [OP_W-1:0] OP_NEG   = 6'h06;
  localparam logic [OP_W-1:0] OP_MUL   = 6'h07;
  localparam logic [OP_W-1:0] OP_DIV   = 6'h08;
  localparam logic [OP_W-1:0] OP_OR    = 6'h09;
  localparam logic [OP_W-1:0] OP_XOR   = 6'h0A;
  localparam logic [OP_W-1:0] OP_NAND  = 6'h0B;
  localparam logic [OP_W-1:0] OP_NOR   = 6'h0C;
  localparam logic [OP_W-1:0] OP_XNOR  = 6'h0D;
  localparam logic [OP_W-1:0] OP_NOT   = 6'h0E;
  localparam logic [OP_W-1:0] OP_LLSH  = 6'h0F;
  localparam logic [OP_W-1:0] OP_LRSH  = 6'h10;
  typedef enum logic [1:0] {IDLE, WR1, WR2, RET} state_t;
endpackage

// File: rtl/wb_result_mux.sv
// wb_result_mux: picks the low/high result words and write count for an opcode
module wb_result_mux
  import alu_wb_pkg::*;
(
  input  logic [OP_W-1:0]     opcode,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   immediate,
  input  logic [DATA_W-1:0]   sum,
  input  logic [DATA_W-1:0]   diff,
  input  logic [DATA_W-1:0]   negate,
  input  logic [DATA_W-1:0]   divi,
  input  logic [2*DATA_W-1:0] multiplied,
  input  logic [DATA_W-1:0]   or_gat,
  input  logic [DATA_W-1:0]   xor_gat,
  input  logic [DATA_W-1:0]   nand_gat,
  input  logic [DATA_W-1:0]   nor_gat,
  input  logic [DATA_W-1:0]   xnor_gat,
  input  logic [DATA_W-1:0]   not_gat,
  input  logic [DATA_W-1:0]   shl,
  input  logic [DATA_W-1:0]   shr,
  output logic [DATA_W-1:0]   lo,
  output logic [DATA_W-1:0]   hi,
  output logic [1:0]          count,
  output logic                legal
);
  // legal is low for unmapped opcodes and for a divide by zero; both retire with err
  always_comb begin
    lo = '0;
    hi = '0;
    count = 2'd1;
    legal = 1'b1;
    case (opcode)
      OP_MOV:   lo = a;
      OP_MOVI:  lo = immediate;
      OP_LOAD:  count = 2'd0;
      OP_STORE: count = 2'd0;
      OP_ADD:   lo = sum;
      OP_SUB:   lo = diff;
      OP_NEG:   lo = negate;
      OP_MUL: begin
        lo = multiplied[DATA_W-1:0];
        hi = multiplied[2*DATA_W-1:DATA_W];
        count = 2'd2;
      end
      OP_DIV: begin
        lo = divi;
        count = (a == '0) ? 2'd0 : 2'd1;
        legal = (a != '0);
      end
      OP_OR:    lo = or_gat;
      OP_XOR:   lo = xor_gat;
      OP_NAND:  lo = nand_gat;
      OP_NOR:   lo = nor_gat;
      OP_XNOR:  lo = xnor_gat;
      OP_NOT:   lo = not_gat;
      OP_LLSH:  lo = shl;
      OP_LRSH:  lo = shr;
      default: begin
        count = 2'd0;
        legal = 1'b0;
      end
    endcase
  end
endmodule

// File: rtl/alu_writeback.sv
// alu_writeback: captures the selected ALU result and writes it out one word per cycle
module alu_writeback
  import alu_wb_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_W-1:0]     opcode,
  input  logic [ADDR_W-1:0]   rdst1,
  input  logic [ADDR_W-1:0]   rdst2,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   immediate,
  input  logic [DATA_W-1:0]   sum,
  input  logic [DATA_W-1:0]   diff,
  input  logic [DATA_W-1:0]   negate,
  input  logic [DATA_W-1:0]   divi,
  input  logic [2*DATA_W-1:0] multiplied,
  input  logic [DATA_W-1:0]   or_gat,
  input  logic [DATA_W-1:0]   xor_gat,
  input  logic [DATA_W-1:0]   nand_gat,
  input  logic [DATA_W-1:0]   nor_gat,
  input  logic [DATA_W-1:0]   xnor_gat,
  input  logic [DATA_W-1:0]   not_gat,
  input  logic [DATA_W-1:0]   shl,
  input  logic [DATA_W-1:0]   shr,
  input  logic                mem_busy,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic                done,
  output logic                flag_z,
  output logic                flag_n,
  output logic                err
);
  state_t state;
  logic [DATA_W-1:0] lo, hi, lo_q, hi_q;
  logic [ADDR_W-1:0] rdst2_q;
  logic [1:0] count;
  logic legal, mul_q;
  wb_result_mux u_mux (
    .opcode(opcode), .a(a), .immediate(immediate), .sum(sum), .diff(diff),
    .negate(negate), .divi(divi), .multiplied(multiplied), .or_gat(or_gat),
    .xor_gat(xor_gat), .nand_gat(nand_gat), .nor_gat(nor_gat), .xnor_gat(xnor_gat),
    .not_gat(not_gat), .shl(shl), .shr(shr), .lo(lo), .hi(hi), .count(count),
    .legal(legal)
  );
  // done follows the write port handshake, so it is decoded from the stall input this cycle
  assign done = (state == RET) | (wr_en & !mem_busy & ((state == WR2) | !mul_q));
  // FSM with registered write port, ready and error outputs; flags load when a writing instruction retires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b1;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      err <= 1'b0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      lo_q <= '0;
      hi_q <= '0;
      rdst2_q <= '0;
      mul_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          lo_q <= lo;
          hi_q <= hi;
          rdst2_q <= rdst2;
          mul_q <= (count == 2'd2);
          in_ready <= 1'b0;
          if (count != 2'd0) begin
            state <= WR1;
            wr_en <= 1'b1;
            wr_addr <= rdst1;
            wr_data <= lo;
          end else begin
            state <= RET;
            err <= !legal;
          end
        end
        WR1, WR2: if (!mem_busy) begin
          if (state == WR1 && mul_q) begin
            state <= WR2;
            wr_addr <= rdst2_q;
            wr_data <= hi_q;
          end else begin
            state <= IDLE;
            in_ready <= 1'b1;
            wr_en <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            flag_z <= (lo_q == '0) && (hi_q == '0);
            flag_n <= mul_q ? hi_q[DATA_W-1] : lo_q[DATA_W-1];
          end
        end
        RET: begin
          state <= IDLE;
          in_ready <= 1'b1;
          err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed and random instructions checked against a per-opcode reference model
module tb_alu_writeback;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [5:0] opcode = '0;
  logic [4:0] rdst1 = '0, rdst2 = '0;
  logic [15:0] a = '0, immediate = '0, sum = '0, diff = '0, negate = '0, divi = '0;
  logic [31:0] multiplied = '0;
  logic [15:0] or_gat = '0, xor_gat = '0, nand_gat = '0, nor_gat = '0, xnor_gat = '0, not_gat = '0;
  logic [15:0] shl = '0, shr = '0;
  logic mem_busy = 1'b0, wr_en, done, flag_z, flag_n, err;
  logic [4:0] wr_addr;
  logic [15:0] wr_data;
  int errors = 0, checks = 0;
  logic mz = 1'b0, mn = 1'b0;
  alu_writeback dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .rdst1(rdst1), .rdst2(rdst2), .a(a), .immediate(immediate), .sum(sum), .diff(diff),
    .negate(negate), .divi(divi), .multiplied(multiplied), .or_gat(or_gat), .xor_gat(xor_gat),
    .nand_gat(nand_gat), .nor_gat(nor_gat), .xnor_gat(xnor_gat), .not_gat(not_gat),
    .shl(shl), .shr(shr), .mem_busy(mem_busy), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .done(done), .flag_z(flag_z), .flag_n(flag_n), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic scramble();
    a = 16'($urandom); immediate = 16'($urandom); sum = 16'($urandom); diff = 16'($urandom);
    negate = 16'($urandom); divi = 16'($urandom); multiplied = $urandom;
    or_gat = 16'($urandom); xor_gat = 16'($urandom); nand_gat = 16'($urandom);
    nor_gat = 16'($urandom); xnor_gat = 16'($urandom); not_gat = 16'($urandom);
    shl = 16'($urandom); shr = 16'($urandom);
  endtask
  task automatic idle_checks(input string tag);
    check({tag, " in_ready"}, 32'(in_ready), 1);
    check({tag, " wr_en"}, 32'(wr_en), 0);
    check({tag, " wr_addr"}, 32'(wr_addr), 0);
    check({tag, " wr_data"}, 32'(wr_data), 0);
    check({tag, " done"}, 32'(done), 0);
    check({tag, " err"}, 32'(err), 0);
    check({tag, " flag_z"}, 32'(flag_z), 32'(mz));
    check({tag, " flag_n"}, 32'(flag_n), 32'(mn));
  endtask
  // stall < 0 picks a random 0..2 stall before each word
  task automatic do_instr(input logic [5:0] op, input logic [4:0] r1, input logic [4:0] r2, input int stall);
    logic [15:0] res [0:16];
    logic [15:0] vals [2];
    logic [4:0] adrs [2];
    int nwr, st;
    logic err_e;
    res = '{a, immediate, 16'h0, 16'h0, sum, diff, negate, multiplied[15:0], divi,
            or_gat, xor_gat, nand_gat, nor_gat, xnor_gat, not_gat, shl, shr};
    err_e = (op > 6'h10) || (op == 6'h08 && a == 16'h0);
    nwr = (err_e || op == 6'h02 || op == 6'h03) ? 0 : (op == 6'h07) ? 2 : 1;
    vals[0] = (op <= 6'h10) ? res[op[4:0]] : 16'h0;
    vals[1] = multiplied[31:16];
    adrs[0] = r1;
    adrs[1] = r2;
    @(negedge clk);
    opcode = op; rdst1 = r1; rdst2 = r2; in_valid = 1'b1; mem_busy = 1'($urandom);
    #1 check("accept in_ready", 32'(in_ready), 1);
    if (op == 6'h07) begin
      mz = (multiplied == 32'h0);
      mn = multiplied[31];
    end else if (nwr == 1) begin
      mz = (vals[0] == 16'h0);
      mn = vals[0][15];
    end
    @(negedge clk);
    in_valid = 1'b0; rdst1 = 5'($urandom); rdst2 = 5'($urandom); opcode = 6'($urandom);
    scramble();
    for (int w = 0; w < nwr; w++) begin
      st = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
      for (int s = 0; s < st; s++) begin
        mem_busy = 1'b1;
        #1 check("stall wr_en", 32'(wr_en), 1);
        check("stall wr_addr", 32'(wr_addr), 32'(adrs[w]));
        check("stall wr_data", 32'(wr_data), 32'(vals[w]));
        check("stall done", 32'(done), 0);
        check("stall in_ready", 32'(in_ready), 0);
        @(negedge clk);
      end
      mem_busy = 1'b0;
      #1 check("write wr_en", 32'(wr_en), 1);
      check("write wr_addr", 32'(wr_addr), 32'(adrs[w]));
      check("write wr_data", 32'(wr_data), 32'(vals[w]));
      check("write done", 32'(done), 32'(w == nwr - 1));
      check("write err", 32'(err), 0);
      @(negedge clk);
    end
    if (nwr == 0) begin
      #1 check("ret wr_en", 32'(wr_en), 0);
      check("ret done", 32'(done), 1);
      check("ret err", 32'(err), 32'(err_e));
      check("ret in_ready", 32'(in_ready), 0);
      @(negedge clk);
    end
    mem_busy = 1'b0;
    #1 idle_checks("after");
  endtask
  initial begin
    scramble();
    #12 idle_checks("reset");
    @(negedge clk) rst_n = 1'b1;
    scramble(); sum = 16'h1234;
    do_instr(6'h04, 5'd3, 5'd9, 0);
    scramble(); multiplied = 32'h8000_0001;
    do_instr(6'h07, 5'd4, 5'd5, 0);
    scramble(); diff = 16'h0000;
    do_instr(6'h05, 5'd7, 5'd1, 3);
    scramble(); do_instr(6'h2A, 5'd2, 5'd2, 0);
    scramble(); a = 16'h0000; do_instr(6'h08, 5'd6, 5'd8, 0);
    scramble(); do_instr(6'h03, 5'd1, 5'd2, 0);
    scramble(); a = 16'h0005; divi = 16'h8001; do_instr(6'h08, 5'd0, 5'd0, 1);
    scramble(); multiplied = 32'h0;
    do_instr(6'h07, 5'd31, 5'd0, 1);
    scramble(); multiplied = 32'h1234_5678;
    @(negedge clk);
    opcode = 6'h07; rdst1 = 5'd10; rdst2 = 5'd11; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; mem_busy = 1'b0;
    #1 check("pre-reset wr_en", 32'(wr_en), 1);
    rst_n = 1'b0;
    mz = 1'b0; mn = 1'b0;
    #1 idle_checks("mid-reset");
    @(negedge clk) rst_n = 1'b1;
    #1 idle_checks("post-reset");
    @(negedge clk);
    #1 check("no WR2 wr_en", 32'(wr_en), 0);
    scramble(); sum = 16'hFFFE;
    do_instr(6'h04, 5'd12, 5'd13, 0);
    for (int i = 0; i < 60; i++) begin
      scramble();
      if ($urandom_range(0, 3) == 0) a = 16'h0;
      if ($urandom_range(0, 7) == 0) multiplied = 32'h0;
      do_instr((i % 9 == 8) ? 6'($urandom_range(17, 63)) : 6'($urandom_range(0, 16)),
               5'($urandom), 5'($urandom), -1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
Writeback stage directly downstream of the ALU result mux (muxfinal). It takes the decoded opcode, the destination register fields, and the parallel ALU result buses, then selects the result for the opcode. It writes that result into the register/data memory through a stallable write port, spending one cycle per destination word. MUL writes its 32-bit product as two words (Rdst1 = low half, Rdst2 = high half); the stage also keeps zero/negative status flags.

Parameters:
DATA_W, 16, operand/result word width
ADDR_W, 5, register address width (code[25:21], code[20:16])
OP_W, 6, opcode width (code[31:26])

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  ALU results and fields valid this cycle
in_ready  output  1  stage can accept (high only in IDLE)
opcode  input  OP_W  instruction select
rdst1, rdst2  input  ADDR_W each  destination fields (low word, high word)
a, immediate  input  DATA_W each  source operand Rsrc1 value; immediate field
sum, diff, negate, divi  input  DATA_W each  arithmetic results
multiplied  input  2*DATA_W  product
or_gat, xor_gat, nand_gat, nor_gat, xnor_gat, not_gat  input  DATA_W each  logic results
shl, shr  input  DATA_W each  left/right shift results
mem_busy  input  1  write port stall; write not taken while high
wr_en  output  1  write strobe
wr_addr  output  ADDR_W  write address
wr_data  output  DATA_W  write data
done  output  1  one-cycle pulse when instruction retires
flag_z, flag_n  output  1 each  zero/negative status (registered)
err  output  1  one-cycle pulse on illegal opcode or divide-by-zero

Behaviour:
- Reset (async, rst_n=0): state IDLE. in_ready=1. wr_en, wr_addr, wr_data, done, flag_z, flag_n and err are all 0.
- Opcode map: 0x00 MOV (a), 0x01 MOVI (immediate), 0x02 LOAD, 0x03 STORE, 0x04 ADD (sum), 0x05 SUB (diff), 0x06 NEG, 0x07 MUL, 0x08 DIV, 0x09 OR, 0x0A XOR, 0x0B NAND, 0x0C NOR, 0x0D XNOR, 0x0E NOT, 0x0F LLSH (shl), 0x10 LRSH (shr). 0x11-0x3F are illegal.
- Accept: in IDLE, in_valid=1 latches opcode, rdst1, rdst2, lo word, hi word (multiplied[31:16] for MUL, else 0) and the write count.
- Write count is 2 for MUL, 1 for the other computing opcodes and MOV/MOVI, and 0 for LOAD, STORE, illegal opcodes, and DIV with a==0.
- States:
  - IDLE -> WR1 (count≥1) or RET (count 0).
  - WR1: wr_en=1, wr_addr=rdst1, wr_data=lo. Holds while mem_busy=1, with address and data stable. On !mem_busy: -> WR2 if count=2, else IDLE.
  - WR2: wr_en=1, wr_addr=rdst2, wr_data=hi. Same stall rule. -> IDLE.
  - RET: no write. done=1; err=1 for illegal opcode or DIV with a==0. -> IDLE.
- done is asserted in the cycle the final write is taken (wr_en & !mem_busy), or in RET.
- Latency with no stall: accept at cycle N, first write at N+1, MUL second write at N+2, in_ready high again at N+2 (N+3 for MUL).
- in_ready=0 in every state other than IDLE; in_valid is ignored there.
- Flags update only in the cycle done is asserted and only for write-count≥1 instructions.
  - Non-MUL: flag_z = (lo==0), flag_n = lo[15].
  - MUL: flag_z = (multiplied==0), flag_n = hi[15].
  - LOAD, STORE, and error cases leave the flags unchanged.
- wr_addr and wr_data are 0 whenever wr_en=0.
- Results are taken as-is from the ALU; no carry or overflow is generated. Register address 0 is writable (no hardwired zero).
- Reset mid-write aborts immediately; the pending write is lost and no done is asserted.

Decomposition:
- Package alu_wb_pkg: opcode localparams (OP_MOV..OP_LRSH), the state encoding (IDLE, WR1, WR2, RET), DATA_W/ADDR_W defaults.
- Sub-module wb_result_mux: combinational; maps opcode and the result buses to lo, hi, write count (0/1/2) and legal. alu_writeback holds the FSM, capture registers and flags.

Test Plan:
- ADD, sum=0x1234, rdst1=3, no stall -> N+1 wr_en=1 addr=3 data=0x1234, done=1, flag_z=0, flag_n=0; N+2 in_ready=1.
- MUL, multiplied=0x8000_0001, rdst1=4, rdst2=5 -> N+1 (addr 4, 0x0001), N+2 (addr 5, 0x8000) with done, flag_n=1.
- SUB, diff=0, mem_busy=1 for 3 cycles -> wr_en held with addr/data stable through the stall, one write taken, flag_z=1.
- Opcode 0x2A, then DIV with a=0 -> no wr_en, done and err pulse each, flags unchanged; STORE -> done, no err, no write.
- Reset asserted during WR1 of a MUL -> all outputs 0 at once, no WR2. After release, ADD executes normally.
